// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state encoding and constants for the block-copy engine
package mem_copy_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int CYCLES_PER_BYTE = 3;
  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_addr_gen.sv
// mem_copy_addr_gen: byte index counter, wrapping source/destination addresses and last-byte flag
module mem_copy_addr_gen import mem_copy_pkg::*; #(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] dst_addr,
  output logic          last
);
  logic [AW-1:0] index;
  always_ff @(posedge clk)
    if (reset || clear) index <= '0;
    else if (inc) index <= index + 1'b1;
  assign src_addr = src + index;
  assign dst_addr = dst + index;
  assign last = index + 1'b1 == length;
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-at-a-time block copier that masters the data memory (read, capture, write).
// Defining MEM_COPY_CHECKSUM_EN adds a checksum output summing every captured byte.
module mem_copy_engine import mem_copy_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  input  logic [DW-1:0] mem_rdata
);
  state_t state, state_nx;
  logic [AW-1:0] src_r, dst_r, len_r, rd_addr, wr_addr;
  logic [DW-1:0] data_r;
  logic accept, last;
  assign accept = state == IDLE && start;
  mem_copy_addr_gen #(.AW(AW)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .inc      (state == WRITE),
    .src      (src_r),
    .dst      (dst_r),
    .length   (len_r),
    .src_addr (rd_addr),
    .dst_addr (wr_addr),
    .last     (last)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (length == '0 ? DONE : READ) : IDLE;
      READ:    state_nx = LATCH;
      LATCH:   state_nx = WRITE;
      WRITE:   state_nx = last ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      src_r  <= '0;
      dst_r  <= '0;
      len_r  <= '0;
      data_r <= '0;
    end else begin
      if (accept) begin
        src_r <= src_addr;
        dst_r <= dst_addr;
        len_r <= length;
      end
      if (state == LATCH) data_r <= mem_rdata;
    end
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_read  = state == READ;
  assign mem_write = state == WRITE;
  assign mem_addr  = mem_read ? rd_addr : mem_write ? wr_addr : '0;
  assign mem_wdata = mem_write ? data_r : '0;
`ifdef MEM_COPY_CHECKSUM_EN
  always_ff @(posedge clk)
    if (reset || accept) checksum <= '0;
    else if (state == LATCH) checksum <= checksum + mem_rdata;
`endif
  assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: randomized and directed copies checked cycle by cycle against a transaction-level model
module tb_mem_copy_engine;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] src_addr = 0, dst_addr = 0, length = 0;
  logic busy, done, mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum;
  logic [7:0] last_cs = 0;
`endif
  typedef struct {
    bit busy, done, rd, wr;
    logic [7:0] addr, wdata, cs;
  } exp_t;
  exp_t q[$];
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0;
  bit run_chk = 0;

  mem_copy_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // data memory: registered read, valid the cycle after mem_read
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] = mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  // expected bus trace of one command: per byte a read, a quiet capture cycle, a write; then done
  task automatic push_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    logic [7:0] tmp [256];
    logic [7:0] v, cs;
    tmp = ref_mem;
    cs = 0;
    for (int i = 0; i < int'(l); i++) begin
      v = tmp[8'(s + i)];
      cs = cs + v;
      q.push_back('{1, 0, 1, 0, 8'(s + i), 8'h0, 8'h0});
      q.push_back('{1, 0, 0, 0, 8'h0, 8'h0, 8'h0});
      q.push_back('{1, 0, 0, 1, 8'(d + i), v, 8'h0});
      tmp[8'(d + i)] = v;
    end
    q.push_back('{1, 1, 0, 0, 8'h0, 8'h0, cs});
  endtask

  always @(negedge clk) if (run_chk) begin
    exp_t e;
    e = q.size() != 0 ? q.pop_front() : '{0, 0, 0, 0, 8'h0, 8'h0, 8'h0};
    chk("ctrl", {busy, done, mem_read, mem_write}, {e.busy, e.done, e.rd, e.wr});
    if (e.rd || e.wr) chk("addr", mem_addr, e.addr);
    if (e.wr) begin
      chk("wdata", mem_wdata, e.wdata);
      ref_mem[e.addr] = e.wdata;
    end
`ifdef MEM_COPY_CHECKSUM_EN
    if (e.done) begin
      chk("checksum", checksum, e.cs);
      last_cs = e.cs;
    end else if (!e.busy) chk("checksum_hold", checksum, last_cs);
`endif
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic mem_eq();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_bytes_differing", bad, 0);
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input int glitch);
    int c = 0;
    @(posedge clk); #1;
    start = 1; src_addr = s; dst_addr = d; length = l;
    @(posedge clk); #1;
    start = 0; src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 8'($urandom);
    push_cmd(s, d, l);
    busy_cnt = 0; done_cnt = 0;
    while (q.size() != 0 && c < 1000) begin
      if (c == glitch) begin
        start = 1; src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 8'($urandom_range(1, 8));
      end
      @(posedge clk); #1;
      start = 0; c++;
    end
    chk("timeout", c >= 1000, 0);
    chk("busy_cycles", busy_cnt, mem_copy_pkg::CYCLES_PER_BYTE * int'(l) + 1);
    chk("done_pulses", done_cnt, 1);
    mem_eq();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[16] = 8'h00; mem[17] = 8'hFF; mem[18] = 8'hFE; mem[19] = 8'hFD;
    mem[254] = 8'hAA; mem[255] = 8'hBB;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    @(posedge clk); #1;
    run_chk = 1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_strobes", {mem_read, mem_write}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    run(8'd0, 8'd64, 8'd4, -1);
    chk("t1_mem", {mem[64], mem[65], mem[66], mem[67]}, 32'h00010203);
    chk("t1_busy13", busy_cnt, 13);
    run(8'd5, 8'd9, 8'd0, -1);
    chk("t2_busy1", busy_cnt, 1);
    run(8'd254, 8'd100, 8'd4, -1);
    chk("t3_wrap_mem", {mem[100], mem[101], mem[102], mem[103]}, 32'hAABB0001);
    run(8'd16, 8'd200, 8'd4, -1);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t4_checksum_lit", checksum, 8'hFA);
`endif
    run(8'd10, 8'd12, 8'd6, -1);
    chk("t5_overlap", {mem[12], mem[13], mem[14], mem[15]}, 32'h0A0B0A0B);
    run(8'd0, 8'd64, 8'd4, 5);
    run(8'd3, 8'd30, 8'd3, 9);

    for (int i = 64; i < 68; i++) begin mem[i] = 8'hEE; ref_mem[i] = 8'hEE; end
    @(posedge clk); #1;
    start = 1; src_addr = 0; dst_addr = 64; length = 4;
    @(posedge clk); #1;
    start = 0;
    push_cmd(8'd0, 8'd64, 8'd4);
    done_cnt = 0;
    repeat (6) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    q.delete();
`ifdef MEM_COPY_CHECKSUM_EN
    last_cs = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt, 0);
    chk("rst_mem", {mem[64], mem[65], mem[66], mem[67]}, 32'h0001EEEE);
    mem_eq();
    run(8'd0, 8'd64, 8'd4, -1);
    chk("after_rst_mem", {mem[64], mem[65], mem[66], mem[67]}, 32'h00010203);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] l;
      int g;
      l = 8'($urandom_range(0, 24));
      g = $urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, 3 * int'(l)));
      run(8'($urandom), 8'($urandom), l, g);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
